ksm_irq_arb: RTL and testbench
==============================

# ksm_irq_arb

Multi-level priority interrupt arbiter for the KSM CPU bus. It collects device interrupt requests on the four PDP-11 bus request levels (BR4–BR7) and masks them against the CPU's current PSW priority. It selects a single winner, runs the vector-fetch handshake with the processor and returns a one-cycle acknowledge to the winning device. It sits between the peripheral IRQ lines and the CPU's vector-fetch port.

## Interface
Parameters:
- `N`, default 8: number of interrupt sources, minimum 1.
- `W`, default `max(1, clog2(N))`: winner index width (derived).

Ports:
- `wb_clk_i`  in  1  system clock. One clock domain.
- `wb_rst_i`  in  1  reset. Synchronous, active-high.
- `psw_pri`  in  3  current CPU priority, PSW[7:5].
- `ireq`  in  N  level request per source.
- `ilvl`  in  2*N  request level per source: 0..3 maps to BR4..BR7.
- `ivec`  in  16*N  vector per source. Source i uses bits [16i+15:16i].
- `iack`  out  N  one-cycle acknowledge to the winning source.
- `wb_irq_o`  out  1  vectored interrupt request to the CPU.
- `wb_stb_i`  in  1  CPU vector-fetch strobe.
- `wb_ack_o`  out  1  vector-valid acknowledge.
- `wb_dat_o`  out  16  vector to the CPU.
- `irq_lvl_o`  out  3  priority of the current or last winner (4..7).

## Operation
- Eligibility: source i is eligible when `ireq[i]` is 1 and `4+ilvl[i] > psw_pri`. The compare is 3-bit unsigned. `psw_pri=7` masks every source.
- Selection: the eligible source with the highest level wins. On a level tie, the lowest index wins.
- FSM states: IDLE, PEND, XFER, WAIT.
- IDLE → PEND:
  - Taken when any source is eligible.
  - Latches the winner index, level and vector.
  - `wb_irq_o` is set to 1 and `irq_lvl_o` is set to 4+level.
- PEND, while `wb_stb_i`=0, re-evaluated every cycle:
  - If a source with a strictly higher level becomes eligible, it replaces the winner: index, level and vector are re-latched and `irq_lvl_o` is updated. The state stays PEND.
  - If the latched winner is no longer eligible (its `ireq` dropped, or `psw_pri` rose) and no other source is eligible, go to IDLE and clear `wb_irq_o`. This is a passive release: no `iack` is issued.
  - If the latched winner is no longer eligible but another source is, re-select the winner and stay in PEND.
- PEND with `wb_stb_i`=1 → XFER:
  - The winner is frozen.
  - `wb_dat_o` is loaded with the latched vector.
  - `wb_ack_o` is set to 1, `iack[win]` is set to 1 and `wb_irq_o` is cleared.
  - The vector delivered is the one latched at the strobe edge, even if `ireq` drops in that cycle.
- XFER → WAIT, unconditionally after one cycle. `wb_ack_o` and `iack` return to 0.
- WAIT → IDLE when `wb_stb_i`=0.
- `wb_stb_i` seen in IDLE, XFER or WAIT is ignored: no ack is generated.
- Reset values: state IDLE. `wb_irq_o`, `wb_ack_o`, `iack`, `wb_dat_o` and `irq_lvl_o` are all 0.
- `wb_dat_o` holds its last vector until the next XFER.

## Timing
- Request to IRQ: `ireq` sampled eligible at edge k → `wb_irq_o`=1 after edge k+1.
- Strobe to acknowledge: `wb_stb_i`=1 sampled in PEND at edge t → `wb_ack_o`, `iack[win]` and `wb_dat_o` are valid after edge t+1. Ack and iack are exactly one cycle wide.
- Withdrawal: loss of eligibility in PEND at edge k → `wb_irq_o`=0 after edge k+1.
- Back-to-back: `wb_stb_i` low at edge s (in WAIT) → IDLE after s+1 → earliest next `wb_irq_o` after s+2.
- Simultaneous strobe and preemption in the same cycle: the strobe wins, and the previously latched winner is served.
- Reset is taken at any clock edge, in any state, and overrides all other activity. An in-flight XFER is aborted with no iack.

## Structure
- Shared package `ksm_irq_pkg` holds:
  - the state encoding (IDLE, PEND, XFER, WAIT);
  - the constant `BR_BASE=4`;
  - the constant `VEC_W=16`;
  - a `clog2` function.
- One combinational sub-module, `ksm_irq_pick`:
  - inputs: `ireq`, `ilvl`, `psw_pri`, and a `min_lvl` threshold used for the preemption check;
  - outputs: `valid`, `idx[W-1:0]`, `lvl[1:0]`.
  - The top level instantiates it twice: once for general selection and once for strictly-higher preemption.

## Test plan
- **Single request:** N=8, `psw_pri`=0, `ireq[2]`=1, `ilvl[2]`=1, `ivec[2]`=0o060 → `wb_irq_o`=1 one cycle later with `irq_lvl_o`=5. Strobe → `wb_ack_o`=1, `wb_dat_o`=0o060 and `iack`=8'h04 for one cycle, then idle after the strobe drops.
- **Level tie:** `ireq[1]` and `ireq[5]` both at level 2 → first transfer delivers `ivec[1]` with `iack[1]`. The second transfer delivers `ivec[5]`.
- **Masking:** `psw_pri`=5.
  - Source 0 at level 1 (BR5) alone → `wb_irq_o` stays 0.
  - Add source 3 at level 2 → `wb_irq_o`=1 with `irq_lvl_o`=6.
  - Raise `psw_pri` to 6 before the strobe → `wb_irq_o`=0 next cycle, no `iack`.
- **Preemption:** source 0 at BR4 pending, then source 7 at BR7 asserts before the strobe → `irq_lvl_o`=7, strobe delivers `ivec[7]` and `iack[7]`. Source 0 is served on the following transfer.
- **Passive release:**
  - `ireq` drops while in PEND → `wb_irq_o`=0 next cycle, no `iack`.
  - `ireq` drops in the same cycle as the strobe → the latched vector is still delivered and `iack` still pulses.
- **Reset mid-transfer:** assert `wb_rst_i` in XFER → after the next edge all outputs are 0 and the state is IDLE. A request still present after reset release is served normally.

Source files
------------

// File: rtl/ksm_irq_pkg.sv
//------------------------------------------------------------------------------
// ksm_irq_pkg
// Shared definitions for the KSM bus interrupt arbiter.
//   state_t : arbiter FSM encoding (IDLE, PEND, XFER, WAIT)
//   BR_BASE : bus request level of ilvl code 0 (BR4)
//   VEC_W   : width of an interrupt vector
//   clog2   : ceiling log2 used to size the winner index
//------------------------------------------------------------------------------
package ksm_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no request posted to the CPU
        ST_PEND = 2'd1,  // wb_irq_o high, waiting for the vector-fetch strobe
        ST_XFER = 2'd2,  // vector on the bus, ack/iack pulsing
        ST_WAIT = 2'd3   // waiting for the CPU to release the strobe
    } state_t;

    localparam int BR_BASE = 4;
    localparam int VEC_W   = 16;

    // Ceiling log2; clog2(1) = 0, callers clamp the result to at least 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ksm_irq_arb_if.sv
//------------------------------------------------------------------------------
// ksm_irq_arb_if
// CPU vector-fetch port of the interrupt arbiter.
//   wb_irq_o  : vectored interrupt request to the CPU
//   wb_stb_i  : CPU vector-fetch strobe
//   wb_ack_o  : vector-valid acknowledge (one cycle)
//   wb_dat_o  : interrupt vector
//   irq_lvl_o : priority of the current or last winner (4..7)
// Modports: slave = arbiter side, master = CPU side.
//------------------------------------------------------------------------------
interface ksm_irq_arb_if;
    import ksm_irq_pkg::*;

    logic             wb_irq_o;
    logic             wb_stb_i;
    logic             wb_ack_o;
    logic [VEC_W-1:0] wb_dat_o;
    logic [2:0]       irq_lvl_o;

    modport slave (
        output wb_irq_o,
        input  wb_stb_i,
        output wb_ack_o,
        output wb_dat_o,
        output irq_lvl_o
    );

    modport master (
        input  wb_irq_o,
        output wb_stb_i,
        input  wb_ack_o,
        input  wb_dat_o,
        input  irq_lvl_o
    );

endinterface

// File: rtl/ksm_irq_pick.sv
//------------------------------------------------------------------------------
// ksm_irq_pick
// Combinational winner selection among N interrupt sources.
// A source takes part when it requests, its bus level (BR_BASE + ilvl) is
// above psw_pri, and its ilvl code is at least min_lvl. The highest ilvl
// wins; on a tie the lowest index wins.
//   ireq    [N-1:0]   : request per source
//   ilvl    [2N-1:0]  : level code per source (0..3 = BR4..BR7)
//   psw_pri [2:0]     : current CPU priority
//   min_lvl [2:0]     : minimum level code (4 disqualifies everything)
//   valid             : at least one source qualifies
//   idx     [W-1:0]   : winning source index
//   lvl     [1:0]     : winning level code
//------------------------------------------------------------------------------
module ksm_irq_pick
    import ksm_irq_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0]   ireq,
    input  logic [2*N-1:0] ilvl,
    input  logic [2:0]     psw_pri,
    input  logic [2:0]     min_lvl,
    output logic           valid,
    output logic [W-1:0]   idx,
    output logic [1:0]     lvl
);

    logic [N-1:0] w_elig;

    // 3-bit unsigned compare; BR_BASE + 3 = 7 never overflows.
    for (genvar i = 0; i < N; i++) begin : g_elig
        assign w_elig[i] = ireq[i]
                        && ((3'(BR_BASE) + {1'b0, ilvl[2*i +: 2]}) > psw_pri)
                        && ({1'b0, ilvl[2*i +: 2]} >= min_lvl);
    end

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        lvl   = '0;
        // Ascending scan with a strict compare keeps the lowest index on ties.
        for (int i = 0; i < N; i++) begin
            if (w_elig[i] && (!valid || (ilvl[2*i +: 2] > lvl))) begin
                valid = 1'b1;
                idx   = W'(i);
                lvl   = ilvl[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/ksm_irq_arb.sv
//------------------------------------------------------------------------------
// ksm_irq_arb
// Multi-level priority interrupt arbiter for the KSM CPU bus. Masks BR4..BR7
// device requests against the PSW priority, selects one winner, runs the
// vector-fetch handshake and pulses iack to the served device.
//   wb_clk_i  : system clock
//   wb_rst_i  : synchronous active-high reset
//   psw_pri   : CPU priority PSW[7:5]
//   ireq      : level request per source
//   ilvl      : level code per source (2 bits each, 0..3 = BR4..BR7)
//   ivec      : vector per source (16 bits each)
//   iack      : one-cycle acknowledge to the served source
//   bus       : CPU vector-fetch port (irq, stb, ack, dat, irq_lvl)
//------------------------------------------------------------------------------
module ksm_irq_arb
    import ksm_irq_pkg::*;
#(
    parameter int N = 8,
    parameter int W = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [2:0]         psw_pri,
    input  logic [N-1:0]       ireq,
    input  logic [2*N-1:0]     ilvl,
    input  logic [VEC_W*N-1:0] ivec,
    output logic [N-1:0]       iack,
    ksm_irq_arb_if.slave       bus
);

    state_t           r_state;
    logic [W-1:0]     r_idx;
    logic [1:0]       r_lvl;
    logic [VEC_W-1:0] r_vec;
    logic             r_irq;
    logic             r_ack;
    logic [N-1:0]     r_iack;
    logic [VEC_W-1:0] r_dat;
    logic [2:0]       r_irq_lvl;

    logic             w_any_valid;
    logic [W-1:0]     w_any_idx;
    logic [1:0]       w_any_lvl;
    logic [VEC_W-1:0] w_any_vec;
    logic             w_pre_valid;
    logic [W-1:0]     w_pre_idx;
    logic [1:0]       w_pre_lvl;
    logic [2:0]       w_pre_min;
    logic [1:0]       w_win_ilvl;
    logic             w_win_elig;

    // General selection: best eligible source regardless of the current winner.
    ksm_irq_pick #(.N(N), .W(W)) u_pick_any (
        .ireq    (ireq),
        .ilvl    (ilvl),
        .psw_pri (psw_pri),
        .min_lvl (3'd0),
        .valid   (w_any_valid),
        .idx     (w_any_idx),
        .lvl     (w_any_lvl)
    );

    // Preemption check: only sources strictly above the latched level.
    // A latched BR7 winner gives min_lvl = 4, which nothing can reach.
    assign w_pre_min = {1'b0, r_lvl} + 3'd1;

    ksm_irq_pick #(.N(N), .W(W)) u_pick_pre (
        .ireq    (ireq),
        .ilvl    (ilvl),
        .psw_pri (psw_pri),
        .min_lvl (w_pre_min),
        .valid   (w_pre_valid),
        .idx     (w_pre_idx),
        .lvl     (w_pre_lvl)
    );

    assign w_any_vec  = ivec[VEC_W*int'(w_any_idx) +: VEC_W];
    assign w_win_ilvl = ilvl[2*int'(r_idx) +: 2];
    assign w_win_elig = ireq[r_idx]
                     && ((3'(BR_BASE) + {1'b0, w_win_ilvl}) > psw_pri);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_lvl     <= '0;
            r_vec     <= '0;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_iack    <= '0;
            r_dat     <= '0;
            r_irq_lvl <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_idx     <= w_any_idx;
                        r_lvl     <= w_any_lvl;
                        r_vec     <= w_any_vec;
                        r_irq     <= 1'b1;
                        r_irq_lvl <= 3'(BR_BASE) + {1'b0, w_any_lvl};
                        r_state   <= ST_PEND;
                    end
                end

                ST_PEND: begin
                    if (bus.wb_stb_i) begin
                        // Strobe beats preemption and withdrawal: serve the
                        // winner latched before this edge.
                        r_dat   <= r_vec;
                        r_ack   <= 1'b1;
                        r_iack  <= N'(1) << r_idx;
                        r_irq   <= 1'b0;
                        r_state <= ST_XFER;
                    end else if (w_pre_valid || (!w_win_elig && w_any_valid)) begin
                        // The general pick is the right new winner in both
                        // cases: anything strictly higher is also the best
                        // eligible source overall.
                        r_idx     <= w_any_idx;
                        r_lvl     <= w_any_lvl;
                        r_vec     <= w_any_vec;
                        r_irq_lvl <= 3'(BR_BASE) + {1'b0, w_any_lvl};
                    end else if (!w_win_elig) begin
                        // Passive release: nothing left to post, no iack.
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_XFER: begin
                    r_ack   <= 1'b0;
                    r_iack  <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!bus.wb_stb_i) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign iack          = r_iack;
    assign bus.wb_irq_o  = r_irq;
    assign bus.wb_ack_o  = r_ack;
    assign bus.wb_dat_o  = r_dat;
    assign bus.irq_lvl_o = r_irq_lvl;

endmodule

// File: tb/tb_ksm_irq_arb.sv
//------------------------------------------------------------------------------
// tb_ksm_irq_arb
// Self-checking bench for ksm_irq_arb (N=8). Each CPU vector fetch pushes the
// expected vector/iack onto a scoreboard; a negedge monitor pops and compares
// whenever the arbiter acknowledges.
//------------------------------------------------------------------------------
module tb_ksm_irq_arb;
    import ksm_irq_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic [VEC_W-1:0] vec;
        logic [N-1:0]     iack;
    } exp_t;

    logic               wb_clk_i;
    logic               wb_rst_i;
    logic [2:0]         psw_pri;
    logic [N-1:0]       ireq;
    logic [2*N-1:0]     ilvl;
    logic [VEC_W*N-1:0] ivec;
    logic [N-1:0]       iack;

    ksm_irq_arb_if u_bus ();

    ksm_irq_arb #(.N(N)) u_dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .psw_pri  (psw_pri),
        .ireq     (ireq),
        .ilvl     (ilvl),
        .ivec     (ivec),
        .iack     (iack),
        .bus      (u_bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   mon_en   = 1'b0;
    logic prev_ack = 1'b0;

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic set_src(input int i, input logic rq, input logic [1:0] lv,
                           input logic [VEC_W-1:0] vec);
        ireq[i]           = rq;
        ilvl[2*i +: 2]    = lv;
        ivec[16*i +: 16]  = vec;
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 20 && u_bus.wb_irq_o !== 1'b1; i++) tick();
        check(tag, u_bus.wb_irq_o, 1'b1);
    endtask

    // One CPU vector fetch of source src. With drop_early the device drops
    // its request in the same cycle as the strobe.
    task automatic serve(input int src, input bit drop_early);
        exp_t e;
        e.vec  = ivec[16*src +: 16];
        e.iack = N'(1) << src;
        exp_q.push_back(e);
        u_bus.wb_stb_i = 1'b1;
        if (drop_early) ireq[src] = 1'b0;
        tick();
        check("xfer_ack", u_bus.wb_ack_o, 1'b1);
        check("xfer_irq_clr", u_bus.wb_irq_o, 1'b0);
        u_bus.wb_stb_i = 1'b0;
        ireq[src]      = 1'b0;
        tick();
        check("wait_ack_low", u_bus.wb_ack_o, 1'b0);
        check("wait_iack_low", iack, '0);
        tick();
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            if (u_bus.wb_ack_o === 1'b1) begin
                check("ack_width", prev_ack, 1'b0);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    check("sb_vec", u_bus.wb_dat_o, exp_q[0].vec);
                    check("sb_iack", iack, exp_q[0].iack);
                    void'(exp_q.pop_front());
                end
            end else begin
                check("iack_idle", iack, '0);
            end
            prev_ack <= u_bus.wb_ack_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_i       = 1'b1;
        psw_pri        = 3'd0;
        ireq           = '0;
        ilvl           = '0;
        ivec           = '0;
        u_bus.wb_stb_i = 1'b0;
        repeat (3) tick();
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;

        // Reset state
        check("rst_irq", u_bus.wb_irq_o, 1'b0);
        check("rst_ack", u_bus.wb_ack_o, 1'b0);
        check("rst_iack", iack, '0);
        check("rst_dat", u_bus.wb_dat_o, '0);
        check("rst_lvl", u_bus.irq_lvl_o, '0);

        // Single request
        set_src(2, 1'b1, 2'd1, 16'o060);
        #0 check("single_pre_irq", u_bus.wb_irq_o, 1'b0);
        tick();
        check("single_irq", u_bus.wb_irq_o, 1'b1);
        check("single_lvl", u_bus.irq_lvl_o, 3'd5);
        serve(2, 1'b0);
        tick();
        check("single_idle_irq", u_bus.wb_irq_o, 1'b0);
        check("dat_hold", u_bus.wb_dat_o, 16'o060);

        // Level tie: lowest index first
        set_src(1, 1'b1, 2'd2, 16'o100);
        set_src(5, 1'b1, 2'd2, 16'o104);
        tick();
        check("tie_lvl", u_bus.irq_lvl_o, 3'd6);
        serve(1, 1'b0);
        wait_irq("tie_second_irq");
        check("tie_second_lvl", u_bus.irq_lvl_o, 3'd6);
        serve(5, 1'b0);

        // Masking against PSW priority
        psw_pri = 3'd5;
        set_src(0, 1'b1, 2'd1, 16'o200);
        tick();
        tick();
        check("mask_br5", u_bus.wb_irq_o, 1'b0);
        set_src(3, 1'b1, 2'd2, 16'o204);
        tick();
        check("mask_br6_irq", u_bus.wb_irq_o, 1'b1);
        check("mask_br6_lvl", u_bus.irq_lvl_o, 3'd6);
        psw_pri = 3'd6;
        tick();
        check("mask_raise_irq", u_bus.wb_irq_o, 1'b0);
        ireq    = '0;
        psw_pri = 3'd0;
        tick();

        // Preemption by a strictly higher level
        set_src(0, 1'b1, 2'd0, 16'o300);
        tick();
        check("pre_lvl_br4", u_bus.irq_lvl_o, 3'd4);
        set_src(7, 1'b1, 2'd3, 16'o374);
        tick();
        check("pre_lvl_br7", u_bus.irq_lvl_o, 3'd7);
        check("pre_irq", u_bus.wb_irq_o, 1'b1);
        serve(7, 1'b0);
        wait_irq("pre_next_irq");
        check("pre_next_lvl", u_bus.irq_lvl_o, 3'd4);
        serve(0, 1'b0);

        // Passive release, then request drop in the strobe cycle
        set_src(4, 1'b1, 2'd1, 16'o070);
        tick();
        check("rel_irq", u_bus.wb_irq_o, 1'b1);
        ireq[4] = 1'b0;
        tick();
        check("rel_irq_drop", u_bus.wb_irq_o, 1'b0);
        ireq[4] = 1'b1;
        tick();
        check("rel_irq_again", u_bus.wb_irq_o, 1'b1);
        serve(4, 1'b1);

        // Strobe and preemption in the same cycle: latched winner is served
        set_src(1, 1'b1, 2'd0, 16'o110);
        tick();
        check("race_lvl", u_bus.irq_lvl_o, 3'd4);
        set_src(6, 1'b1, 2'd3, 16'o364);
        serve(1, 1'b0);
        wait_irq("race_next_irq");
        check("race_next_lvl", u_bus.irq_lvl_o, 3'd7);
        serve(6, 1'b0);

        // PSW 7 masks everything; a stray strobe is ignored
        psw_pri = 3'd7;
        set_src(2, 1'b1, 2'd3, 16'o044);
        tick();
        tick();
        check("psw7_irq", u_bus.wb_irq_o, 1'b0);
        u_bus.wb_stb_i = 1'b1;
        tick();
        check("stb_idle_ack", u_bus.wb_ack_o, 1'b0);
        u_bus.wb_stb_i = 1'b0;
        ireq           = '0;
        psw_pri        = 3'd0;
        tick();

        // Reset during XFER
        set_src(3, 1'b1, 2'd2, 16'o124);
        tick();
        check("rx_irq", u_bus.wb_irq_o, 1'b1);
        begin
            exp_t e;
            e.vec  = 16'o124;
            e.iack = 8'h08;
            exp_q.push_back(e);
        end
        u_bus.wb_stb_i = 1'b1;
        tick();
        check("rx_ack", u_bus.wb_ack_o, 1'b1);
        u_bus.wb_stb_i = 1'b0;
        wb_rst_i       = 1'b1;
        tick();
        check("rx_rst_irq", u_bus.wb_irq_o, 1'b0);
        check("rx_rst_ack", u_bus.wb_ack_o, 1'b0);
        check("rx_rst_iack", iack, '0);
        check("rx_rst_dat", u_bus.wb_dat_o, '0);
        check("rx_rst_lvl", u_bus.irq_lvl_o, '0);
        wb_rst_i = 1'b0;
        wait_irq("rx_after_irq");
        check("rx_after_lvl", u_bus.irq_lvl_o, 3'd6);
        serve(3, 1'b0);

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
